// File: rtl/host_port_arbiter.sv
// host_port_arbiter: shares one OBI/Ibex-style host memory port between
// N_REQ requesters. Round-robin selection with address-phase locking, an
// in-order FIFO of granted requester indices for response routing, an
// outstanding-transaction limit and a sticky flag for stray responses.
module host_port_arbiter #(
    parameter int N_REQ           = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [N_REQ-1:0]                 req_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0]      addr_i,
    input  logic [N_REQ-1:0]                 we_i,
    input  logic [N_REQ*(DATA_WIDTH/8)-1:0]  be_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]      wdata_i,
    output logic [N_REQ-1:0]                 gnt_o,
    output logic [N_REQ-1:0]                 rvalid_o,
    output logic [N_REQ-1:0]                 err_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             host_req_o,
    output logic [ADDR_WIDTH-1:0]            host_addr_o,
    output logic                             host_we_o,
    output logic [DATA_WIDTH/8-1:0]          host_be_o,
    output logic [DATA_WIDTH-1:0]            host_wdata_o,
    input  logic                             host_gnt_i,
    input  logic                             host_rvalid_i,
    input  logic                             host_err_i,
    input  logic [DATA_WIDTH-1:0]            host_rdata_i,
    output logic                             protocol_err_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    // Requester index increment, wrapping at N_REQ (N_REQ need not be a power of 2).
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        if (int'(i) == N_REQ - 1) return '0;
        return i + 1'b1;
    endfunction

    // FIFO pointer increment, wrapping at MAX_OUTSTANDING (also covers depth 1).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == MAX_OUTSTANDING - 1) return '0;
        return p + 1'b1;
    endfunction

    logic [IDX_W-1:0] rr_ptr;
    logic             locked;
    logic [IDX_W-1:0] lock_idx;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] rr_scan;
    logic             cand_found;
    logic [IDX_W-1:0] sel;
    logic             host_req;
    logic             accept;
    logic             pop;
    logic [IDX_W-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] head;

    // Round-robin search: first requesting port at or above rr_ptr, wrapping.
    always_comb begin
        cand       = rr_ptr;
        cand_found = 1'b0;
        rr_scan    = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!cand_found && req_i[rr_scan]) begin
                cand       = rr_scan;
                cand_found = 1'b1;
            end
            rr_scan = idx_inc(rr_scan);
        end
    end

    // A pending (ungranted) address phase keeps its requester selected.
    assign sel = locked ? lock_idx : cand;

    // New requests stall on a full FIFO; a locked request was already admitted.
    // Gating with rstn keeps every output quiet while reset is asserted.
    assign host_req = rstn & req_i[sel] & (locked | (count < CNT_MAX));
    assign accept   = host_req & host_gnt_i;
    assign pop      = rstn & host_rvalid_i & (count != '0);
    assign head     = fifo_mem[rd_ptr];

    // Downstream mux, grant fan-out and response routing.
    always_comb begin
        host_req_o   = host_req;
        host_addr_o  = '0;
        host_we_o    = 1'b0;
        host_be_o    = '0;
        host_wdata_o = '0;
        gnt_o        = '0;
        rvalid_o     = '0;
        err_o        = '0;
        rdata_o      = rstn ? host_rdata_i : '0;
        if (host_req) begin
            host_addr_o  = addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
            host_we_o    = we_i[sel];
            host_be_o    = be_i[sel*BE_WIDTH +: BE_WIDTH];
            host_wdata_o = wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
        end
        gnt_o[sel]     = accept;
        rvalid_o[head] = pop;
        err_o[head]    = pop & host_err_i;
    end

    // Control state: lock, round-robin pointer, FIFO pointers/count, stray-response flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr         <= '0;
            locked         <= 1'b0;
            lock_idx       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            // A dropped request while locked gives host_req=0, which unlocks here.
            locked <= host_req & ~host_gnt_i;
            if (host_req && !host_gnt_i) lock_idx <= sel;
            if (accept) begin
                rr_ptr <= idx_inc(sel);
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (host_rvalid_i && count == '0) protocol_err_o <= 1'b1;
        end
    end

    // FIFO storage holds data only; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr] <= sel;
    end

endmodule

// File: tb/tb_host_port_arbiter.sv
// Testbench for host_port_arbiter: table of per-cycle vectors with a response
// scoreboard, plus hand-written sequences for reset behaviour.
module tb_host_port_arbiter;

    localparam int N  = 4;
    localparam int MO = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic [N-1:0]      req_i;
    logic [N*AW-1:0]   addr_i;
    logic [N-1:0]      we_i;
    logic [N*BW-1:0]   be_i;
    logic [N*DW-1:0]   wdata_i;
    logic [N-1:0]      gnt_o;
    logic [N-1:0]      rvalid_o;
    logic [N-1:0]      err_o;
    logic [DW-1:0]     rdata_o;
    logic              host_req_o;
    logic [AW-1:0]     host_addr_o;
    logic              host_we_o;
    logic [BW-1:0]     host_be_o;
    logic [DW-1:0]     host_wdata_o;
    logic              host_gnt_i;
    logic              host_rvalid_i;
    logic              host_err_i;
    logic [DW-1:0]     host_rdata_i;
    logic              protocol_err_o;

    host_port_arbiter #(
        .N_REQ(N), .MAX_OUTSTANDING(MO), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o), .rdata_o(rdata_o),
        .host_req_o(host_req_o), .host_addr_o(host_addr_o), .host_we_o(host_we_o),
        .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
        .host_gnt_i(host_gnt_i), .host_rvalid_i(host_rvalid_i),
        .host_err_i(host_err_i), .host_rdata_i(host_rdata_i),
        .protocol_err_o(protocol_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       hg;
        logic       rv;
        logic       herr;
        logic       e_hreq;
        int         e_sel;
        logic [3:0] e_gnt;
        logic       e_perr;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs[NV];

    int n_pass = 0;
    int n_chk  = 0;
    int sb_q[$];

    function automatic vec_t mk(input logic [3:0] req, input logic hg, input logic rv,
                                input logic herr, input logic e_hreq, input int e_sel,
                                input logic [3:0] e_gnt, input logic e_perr);
        vec_t v;
        v.req = req; v.hg = hg; v.rv = rv; v.herr = herr;
        v.e_hreq = e_hreq; v.e_sel = e_sel; v.e_gnt = e_gnt; v.e_perr = e_perr;
        return v;
    endfunction

    function automatic logic [31:0] addr_of(input int i);
        return 32'h1000_0040 + 32'(i) * 32'h100;
    endfunction

    // {we, be, wdata} presented downstream for requester i, zero when idle.
    function automatic logic [36:0] ctl_of(input int i, input logic hreq);
        logic [31:0] iv;
        iv = 32'(i);
        if (!hreq) return '0;
        return {iv[0], 4'(i + 1), 32'hA5A5_0000 | iv};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " gnt"},      64'(gnt_o), 64'd0);
        chk({tag, " rvalid"},   64'(rvalid_o), 64'd0);
        chk({tag, " err"},      64'(err_o), 64'd0);
        chk({tag, " rdata"},    64'(rdata_o), 64'd0);
        chk({tag, " host_req"}, 64'(host_req_o), 64'd0);
        chk({tag, " addr"},     64'(host_addr_o), 64'd0);
        chk({tag, " ctl"},      64'({host_we_o, host_be_o, host_wdata_o}), 64'd0);
        chk({tag, " perr"},     64'(protocol_err_o), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [3:0]  erv;
        logic [3:0]  eerr;
        logic [31:0] rd;
        int          h;
        rd = (idx == 2) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(idx));
        req_i = v.req; host_gnt_i = v.hg; host_rvalid_i = v.rv;
        host_err_i = v.herr; host_rdata_i = rd;
        erv = '0; eerr = '0;
        if (v.rv && sb_q.size() > 0) begin
            h = sb_q.pop_front();
            erv[h]  = 1'b1;
            eerr[h] = v.herr;
        end
        if (v.e_gnt != 4'b0000) sb_q.push_back(v.e_sel);
        #1;
        chk($sformatf("v%0d host_req", idx), 64'(host_req_o), 64'(v.e_hreq));
        chk($sformatf("v%0d gnt", idx),      64'(gnt_o), 64'(v.e_gnt));
        chk($sformatf("v%0d addr", idx),     64'(host_addr_o),
            v.e_hreq ? 64'(addr_of(v.e_sel)) : 64'd0);
        chk($sformatf("v%0d ctl", idx),      64'({host_we_o, host_be_o, host_wdata_o}),
            64'(ctl_of(v.e_sel, v.e_hreq)));
        chk($sformatf("v%0d rvalid", idx),   64'(rvalid_o), 64'(erv));
        chk($sformatf("v%0d err", idx),      64'(err_o), 64'(eerr));
        chk($sformatf("v%0d rdata", idx),    64'(rdata_o), 64'(rd));
        chk($sformatf("v%0d perr", idx),     64'(protocol_err_o), 64'(v.e_perr));
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           req      hg    rv    herr  ehreq sel egnt     eperr
        vecs[0]  = mk(4'b0001,1'b1,1'b0,1'b0, 1'b1, 0, 4'b0001, 1'b0); // single read
        vecs[1]  = mk(4'b0000,1'b0,1'b0,1'b0, 1'b0, 0, 4'b0000, 1'b0);
        vecs[2]  = mk(4'b0000,1'b0,1'b1,1'b0, 1'b0, 0, 4'b0000, 1'b0); // DEADBEEF
        vecs[3]  = mk(4'b1111,1'b1,1'b0,1'b0, 1'b1, 1, 4'b0010, 1'b0); // round robin
        vecs[4]  = mk(4'b1111,1'b1,1'b0,1'b0, 1'b1, 2, 4'b0100, 1'b0);
        vecs[5]  = mk(4'b1111,1'b1,1'b0,1'b0, 1'b1, 3, 4'b1000, 1'b0);
        vecs[6]  = mk(4'b1111,1'b1,1'b0,1'b0, 1'b1, 0, 4'b0001, 1'b0);
        vecs[7]  = mk(4'b1111,1'b1,1'b0,1'b0, 1'b0, 0, 4'b0000, 1'b0); // full
        vecs[8]  = mk(4'b1111,1'b1,1'b1,1'b0, 1'b0, 0, 4'b0000, 1'b0); // full + pop
        vecs[9]  = mk(4'b1111,1'b1,1'b1,1'b0, 1'b1, 1, 4'b0010, 1'b0); // push + pop
        vecs[10] = mk(4'b1111,1'b1,1'b0,1'b0, 1'b1, 2, 4'b0100, 1'b0);
        vecs[11] = mk(4'b1111,1'b1,1'b0,1'b0, 1'b0, 0, 4'b0000, 1'b0); // full again
        vecs[12] = mk(4'b0000,1'b0,1'b1,1'b1, 1'b0, 0, 4'b0000, 1'b0); // error resp
        vecs[13] = mk(4'b0000,1'b0,1'b1,1'b0, 1'b0, 0, 4'b0000, 1'b0);
        vecs[14] = mk(4'b0000,1'b0,1'b1,1'b0, 1'b0, 0, 4'b0000, 1'b0);
        vecs[15] = mk(4'b0000,1'b0,1'b1,1'b0, 1'b0, 0, 4'b0000, 1'b0);
        vecs[16] = mk(4'b0011,1'b0,1'b0,1'b0, 1'b1, 0, 4'b0000, 1'b0); // lock on 0
        vecs[17] = mk(4'b1011,1'b0,1'b0,1'b0, 1'b1, 0, 4'b0000, 1'b0); // 3 would win RR
        vecs[18] = mk(4'b0001,1'b0,1'b0,1'b0, 1'b1, 0, 4'b0000, 1'b0); // req1 toggles
        vecs[19] = mk(4'b0011,1'b1,1'b0,1'b0, 1'b1, 0, 4'b0001, 1'b0);
        vecs[20] = mk(4'b0011,1'b1,1'b0,1'b0, 1'b1, 1, 4'b0010, 1'b0);
        vecs[21] = mk(4'b0000,1'b0,1'b1,1'b0, 1'b0, 0, 4'b0000, 1'b0);
        vecs[22] = mk(4'b0000,1'b0,1'b1,1'b0, 1'b0, 0, 4'b0000, 1'b0);
        vecs[23] = mk(4'b0100,1'b0,1'b0,1'b0, 1'b1, 2, 4'b0000, 1'b0); // lock on 2
        vecs[24] = mk(4'b1000,1'b0,1'b0,1'b0, 1'b0, 2, 4'b0000, 1'b0); // 2 drops req
        vecs[25] = mk(4'b1000,1'b1,1'b0,1'b0, 1'b1, 3, 4'b1000, 1'b0);
        vecs[26] = mk(4'b0000,1'b0,1'b1,1'b0, 1'b0, 0, 4'b0000, 1'b0);
        vecs[27] = mk(4'b0100,1'b1,1'b0,1'b0, 1'b1, 2, 4'b0100, 1'b0);
        vecs[28] = mk(4'b0000,1'b0,1'b1,1'b1, 1'b0, 0, 4'b0000, 1'b0); // err for 2
        vecs[29] = mk(4'b0000,1'b0,1'b1,1'b0, 1'b0, 0, 4'b0000, 1'b0); // stray resp
        vecs[30] = mk(4'b0000,1'b0,1'b0,1'b0, 1'b0, 0, 4'b0000, 1'b1); // sticky flag

        for (int i = 0; i < N; i++) begin
            addr_i[i*AW +: AW]  = addr_of(i);
            {we_i[i], be_i[i*BW +: BW], wdata_i[i*DW +: DW]} = ctl_of(i, 1'b1);
        end

        // Reset asserted while inputs are active: every output must stay zero.
        rstn = 1'b1;
        req_i = 4'b1111; host_gnt_i = 1'b1; host_rvalid_i = 1'b1;
        host_err_i = 1'b1; host_rdata_i = 32'h1234_5678;
        #1 rstn = 1'b0;
        #2 chk_all_zero("reset");
        @(negedge clk);
        req_i = '0; host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_err_i = 1'b0;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Three grants outstanding (rr_ptr is 3 here: order 3,0,1), then async reset.
        req_i = 4'b1111; host_gnt_i = 1'b1; host_rvalid_i = 1'b0; host_err_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            logic [3:0] eg;
            eg = '0;
            eg[(3 + k) % 4] = 1'b1;
            sb_q.push_back((3 + k) % 4);
            #1 chk($sformatf("burst%0d gnt", k), 64'(gnt_o), 64'(eg));
            @(posedge clk);
            #1;
        end
        host_rvalid_i = 1'b1; host_rdata_i = 32'h5555_AAAA;
        #1 rstn = 1'b0;
        #1 chk_all_zero("async_rst");
        sb_q.delete();
        req_i = '0; host_gnt_i = 1'b0; host_rvalid_i = 1'b0;
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        // After reset rr_ptr is 0, so requester 0 wins with all requesting.
        req_i = 4'b1111;
        #1;
        chk("post_rst host_req", 64'(host_req_o), 64'd1);
        chk("post_rst addr", 64'(host_addr_o), 64'(addr_of(0)));
        chk("post_rst gnt", 64'(gnt_o), 64'd0);
        chk("post_rst perr", 64'(protocol_err_o), 64'd0);
        @(posedge clk);
        #1;

        // Response for a transaction discarded by reset: no routing, flag set.
        req_i = '0; host_rvalid_i = 1'b1;
        #1;
        chk("late_resp rvalid", 64'(rvalid_o), 64'd0);
        chk("late_resp host_req", 64'(host_req_o), 64'd0);
        @(posedge clk);
        #1;
        host_rvalid_i = 1'b0;
        #1 chk("late_resp perr", 64'(protocol_err_o), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
